// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions.
// Load/store encodings, result select and memory-stage FSM states.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RES_SRC_MEM = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [1:0] res_src;
    logic       mem_write;
    logic [2:0] funct3;
    logic [4:0] rd;
  } ex_mem_ctrl_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory valid/ready bus.
// The memory stage is master; the memory is slave.
interface mem_stage_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);

  logic                     dmem_req;
  logic                     dmem_we;
  logic [ADDRESS_WIDTH-1:0] dmem_addr;
  logic [DATA_WIDTH-1:0]    dmem_wdata;
  logic [3:0]               dmem_be;
  logic                     dmem_ready;
  logic [DATA_WIDTH-1:0]    dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    output dmem_be,
    input  dmem_ready,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_be,
    output dmem_ready,
    output dmem_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for the data-memory bus.
// Store lanes, load extension and misalignment detection.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword out of the read word.
  always_comb begin
    byte_sel = rdata_in[7:0];
    half_sel = offset[1] ? rdata_in[31:16] : rdata_in[15:0];
    unique case (offset)
      2'd0: byte_sel = rdata_in[7:0];
      2'd1: byte_sel = rdata_in[15:8];
      2'd2: byte_sel = rdata_in[23:16];
      2'd3: byte_sel = rdata_in[31:24];
      default: byte_sel = rdata_in[7:0];
    endcase
  end

  // Store lane enables, data replication and alignment check by size.
  always_comb begin
    be         = 4'b1111;
    wdata      = wdata_in;
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << offset;
        wdata = {4{wdata_in[7:0]}};
      end
      2'b01: begin
        be         = 4'b0011 << offset;
        wdata      = {2{wdata_in[15:0]}};
        misaligned = offset[0];
      end
      2'b10: begin
        misaligned = |offset;
      end
      default: begin
        be = 4'b1111;
      end
    endcase
  end

  // Sign/zero extension of the selected load lane.
  always_comb begin
    rdata_ext = '0;
    case (funct3)
      F3_B:  rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      F3_H:  rdata_ext = {{16{half_sel[15]}}, half_sel};
      F3_W:  rdata_ext = rdata_in;
      F3_BU: rdata_ext = {24'h0, byte_sel};
      F3_HU: rdata_ext = {16'h0, half_sel};
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: EX/MEM register plus bus FSM.
// Stalls while a data-memory access is outstanding.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     reg_write_e,
  input  logic [1:0]               res_src_e,
  input  logic                     mem_write_e,
  input  logic [2:0]               funct3_e,
  input  logic [DATA_WIDTH-1:0]    alu_result_e,
  input  logic [DATA_WIDTH-1:0]    write_data_e,
  input  logic [4:0]               rd_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4_e,
  input  logic                     stall_in,
  input  logic                     flush_in,
  mem_stage_if.master              dmem,
  output logic                     reg_write_m,
  output logic [1:0]               res_src_m,
  output logic [DATA_WIDTH-1:0]    alu_result_m,
  output logic [DATA_WIDTH-1:0]    read_data_m,
  output logic [4:0]               rd_m,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_m,
  output logic                     stall_m,
  output logic                     misaligned_m
);

  ex_mem_ctrl_t             ctrl_q;
  logic [DATA_WIDTH-1:0]    alu_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [ADDRESS_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0]    hold_q;
  mem_state_e               state_q;
  mem_state_e               state_d;

  logic        load_en;
  logic        mem_op;
  logic        mis_raw;
  logic        req;
  logic        done;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_ext;

  lsu_align u_align (
    .funct3     (ctrl_q.funct3),
    .offset     (alu_q[1:0]),
    .wdata_in   (wdata_q),
    .rdata_in   (dmem.dmem_rdata),
    .be         (st_be),
    .wdata      (st_wdata),
    .rdata_ext  (ld_ext),
    .misaligned (mis_raw)
  );

  assign mem_op  = ctrl_q.valid
                 & ((ctrl_q.res_src == RES_SRC_MEM)
                 | ctrl_q.mem_write);
  assign req     = mem_op & ~mis_raw
                 & (state_q != ST_HOLD);
  assign done    = req & dmem.dmem_ready;
  assign stall_m = req & ~dmem.dmem_ready;
  assign load_en = ~(stall_m | stall_in);

  // EX/MEM pipeline register; a flush loads an all-zero bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      alu_q   <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
    end else if (load_en) begin
      if (flush_in) begin
        ctrl_q  <= '0;
        alu_q   <= '0;
        wdata_q <= '0;
        pc_q    <= '0;
      end else begin
        ctrl_q.valid     <= 1'b1;
        ctrl_q.reg_write <= reg_write_e;
        ctrl_q.res_src   <= res_src_e;
        ctrl_q.mem_write <= mem_write_e;
        ctrl_q.funct3    <= funct3_e;
        ctrl_q.rd        <= rd_e;
        alu_q            <= alu_result_e;
        wdata_q          <= write_data_e;
        pc_q             <= pc_plus4_e;
      end
    end
  end

  // Bus FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Keep load data from an access that completed under an external stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (done & stall_in) begin
      hold_q <= ld_ext;
    end
  end

  // Next state: wait for ready, park in HOLD if the pipe is frozen.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_WAIT: begin
        if (req) begin
          if (dmem.dmem_ready) begin
            state_d = stall_in ? ST_HOLD : ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_HOLD: begin
        if (!stall_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = req & ctrl_q.mem_write;
  assign dmem.dmem_addr  = req ? {alu_q[ADDRESS_WIDTH-1:2], 2'b00}
                               : '0;
  assign dmem.dmem_wdata = (req & ctrl_q.mem_write) ? st_wdata : '0;
  assign dmem.dmem_be    = req ? (ctrl_q.mem_write ? st_be : 4'hF)
                               : 4'h0;

  assign misaligned_m = mem_op & mis_raw;
  assign reg_write_m  = ctrl_q.reg_write & ~misaligned_m;
  assign res_src_m    = ctrl_q.res_src;
  assign alu_result_m = alu_q;
  assign rd_m         = ctrl_q.rd;
  assign pc_plus4_m   = pc_q;
  assign read_data_m  = (state_q == ST_HOLD) ? hold_q
                      : (done & ~ctrl_q.mem_write) ? ld_ext
                      : '0;

endmodule
